vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 1280x800 VGA output stage.
- Generates hsync/vsync/data-enable from configurable porch/sync/active timing with programmable sync polarity.
- Supports a pixel-clock enable so the block can run on a faster system clock.
- Issues pixel coordinates PIPE cycles ahead of the output pixel, so a pipelined draw engine's colour lands on the correct pixel.
- Sits between the draw logic and the VGA connector pins.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 64, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 200, horizontal back porch (pixels)
- V_ACTIVE, 800, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BP, 24, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 1, asserted level of vsync
- COLOR_W, 4, bits per colour channel
- PIPE, 2, draw-engine latency in pixel ticks from coordinate to colour (0..8)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_en  in  1  pixel tick; all state advances only when 1 (tie high for one pixel per clk)
- draw_r/draw_g/draw_b  in  COLOR_W each  colour for the coordinate issued PIPE ticks earlier
- curr_x  out  11  active-area x of issued coordinate
- curr_y  out  10  active-area y of issued coordinate
- coord_valid  out  1  curr_x/curr_y lie in the active area
- pix_r/pix_g/pix_b  out  COLOR_W each  output colour, zero when not de
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  output pixel is visible
- frame_start  out  1  one-tick pulse with output pixel (0,0)
- line_start  out  1  one-tick pulse with output pixel x=0 of each active line

Behaviour:
- Internal counters: h in 0..H_TOT-1, v in 0..V_TOT-1, where H_TOT = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOT is the same sum over the V parameters.
- Line order: sync, back porch, active, front porch, all starting at h=0. Active region: h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1]. The same order applies vertically.
- Counter update on pix_en:
  - h increments each tick.
  - When h=H_TOT-1: h returns to 0 and v increments.
  - When v=V_TOT-1 at that same point, v returns to 0.
- pix_en=0: every register in the block holds, including counters, coordinate regs, delay line and output regs.
- Stage 0 (registered from counters, 1 tick):
  - coord_valid = active(h,v).
  - curr_x = h-(H_SYNC+H_BP) and curr_y = v-(V_SYNC+V_BP) when valid; otherwise both 0.
- Delay line: hsync_raw, vsync_raw, de_raw, frame_start_raw and line_start_raw are delayed by PIPE ticks from stage 0, then registered together with draw_* into the output regs.
  - If the coordinate is issued at tick t, pix/hsync/vsync/de for it appear at tick t+PIPE+1.
  - PIPE=0: output regs are fed directly from stage 0.
- pix_* = draw_* when delayed de=1; otherwise 0.
- hsync = HSYNC_POL while h in [0, H_SYNC-1], else ~HSYNC_POL. vsync is the same over v and V_SYNC.
- frame_start_raw = active and curr_x=0 and curr_y=0. line_start_raw = active and curr_x=0.
- Reset (rst=1 at clk edge, regardless of pix_en):
  - h=v=0.
  - All delay stages cleared to the inactive state: de=0, pulses=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - pix_*=0, curr_x=curr_y=0, coord_valid=0.
  - The first tick after reset starts a fresh frame at h=v=0.
- Reset mid-frame: same as above; no partial pulse is emitted and the delay line is flushed.
- Coordinate widths: 11-bit x and 10-bit y. H_ACTIVE must be ≤2048 and V_ACTIVE ≤1024; an elaboration-time assertion fails otherwise.
- Defaults reproduce current board timing: H_TOT=1680, V_TOT=828, active h 336..1615, active v 27..826.

Test Plan (small config unless stated):
- Small config for tests 1–4 and 6: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1, PIPE=2, pix_en=1.
1. Release rst, count ticks → hsync low for 3 of every 16 ticks; vsync high for 32 of every 128 ticks; de high for 8 ticks per active line, 32 per frame.
2. Drive draw_r={curr_x[1:0],curr_y[1:0]} delayed 2 ticks by the bench → at every de=1 tick, pix_r equals the expected (x,y) code; pix_*=0 whenever de=0.
3. Observe pulses → frame_start exactly once per 128 ticks, coincident with first de after vsync. line_start 4 times per frame, each on the first de tick of a line.
4. Toggle pix_en 1,0,1,0 → outputs change only on enabled ticks; period doubles to 256 clk per frame; alignment is identical to test 2.
5. Default parameters, PIPE=0 → first de at h=336 of v=27; frame period 1,391,040 ticks; hsync low for 136 ticks per line; vsync high for lines 0..2.
6. Assert rst for 1 clk mid-active line → next cycle de=0, hsync=1, vsync=0, curr_x=curr_y=0. Timing then restarts from h=v=0 with no spurious frame_start before the first full frame.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA timing generator. It sits between a pipelined draw engine
// and the VGA connector pins.
//
// Each line and each frame runs in the order sync, back porch, active, front
// porch, starting at counter value 0. The block issues the active-area
// coordinate PIPE pixel ticks before the matching output pixel. A draw engine
// with PIPE ticks of latency therefore lands its colour on the correct pixel.
// Every register advances only on a pixel tick (pix_en).
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   pix_en       pixel tick; all state holds while low
//   draw_r/g/b   colour for the coordinate issued PIPE ticks earlier
//   curr_x/y     active-area coordinate being issued
//   coord_valid  curr_x/curr_y lie in the active area
//   pix_r/g/b    output colour, zero outside the visible area
//   hsync/vsync  sync outputs with programmable asserted level
//   de           output pixel is visible
//   frame_start  one-tick pulse with output pixel (0,0)
//   line_start   one-tick pulse with output pixel x=0 of each active line
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 64,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 200,
    parameter int V_ACTIVE  = 800,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 3,
    parameter int V_BP      = 24,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b1,
    parameter int COLOR_W   = 4,
    parameter int PIPE      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic [COLOR_W-1:0] draw_r,
    input  logic [COLOR_W-1:0] draw_g,
    input  logic [COLOR_W-1:0] draw_b,
    output logic [10:0]        curr_x,
    output logic [9:0]         curr_y,
    output logic               coord_valid,
    output logic [COLOR_W-1:0] pix_r,
    output logic [COLOR_W-1:0] pix_g,
    output logic [COLOR_W-1:0] pix_b,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_start,
    output logic               line_start
);

    localparam int H_TOT   = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT   = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOT);
    localparam int VW      = $clog2(V_TOT);

    if (H_ACTIVE > 2048) begin : g_chk_h
        $error("vga_timing_gen: H_ACTIVE must not exceed 2048");
    end
    if (V_ACTIVE > 1024) begin : g_chk_v
        $error("vga_timing_gen: V_ACTIVE must not exceed 1024");
    end
    if (PIPE < 0 || PIPE > 8) begin : g_chk_pipe
        $error("vga_timing_gen: PIPE must be in 0..8");
    end

    // Timing flags that travel together through the delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
        logic ls;
    } tim_t;

    localparam tim_t TIM_IDLE = '{hs: ~HSYNC_POL, vs: ~VSYNC_POL, de: 1'b0, fs: 1'b0, ls: 1'b0};

    logic [HW-1:0]      h_q, h_d;
    logic [VW-1:0]      v_q, v_d;
    tim_t               s0_q, s0_d;
    logic [10:0]        curr_x_q, curr_x_d;
    logic [9:0]         curr_y_q, curr_y_d;
    tim_t               tap;
    tim_t               out_q, out_d;
    logic [COLOR_W-1:0] pix_r_q, pix_r_d;
    logic [COLOR_W-1:0] pix_g_q, pix_g_d;
    logic [COLOR_W-1:0] pix_b_q, pix_b_d;
    logic               h_act, v_act, act;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == HW'(H_TOT - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOT - 1)) ? '0 : v_q + 1'b1;
        end

        // Upper bounds use <= last index so a zero front porch cannot wrap.
        h_act = (h_q >= HW'(H_START)) && (h_q <= HW'(H_START + H_ACTIVE - 1));
        v_act = (v_q >= VW'(V_START)) && (v_q <= VW'(V_START + V_ACTIVE - 1));
        act   = h_act && v_act;

        s0_d.hs  = (h_q <= HW'(H_SYNC - 1)) ? HSYNC_POL : ~HSYNC_POL;
        s0_d.vs  = (v_q <= VW'(V_SYNC - 1)) ? VSYNC_POL : ~VSYNC_POL;
        s0_d.de  = act;
        s0_d.ls  = act && (h_q == HW'(H_START));
        s0_d.fs  = act && (h_q == HW'(H_START)) && (v_q == VW'(V_START));
        curr_x_d = act ? 11'(h_q - HW'(H_START)) : '0;
        curr_y_d = act ? 10'(v_q - VW'(V_START)) : '0;

        out_d   = tap;
        pix_r_d = tap.de ? draw_r : '0;
        pix_g_d = tap.de ? draw_g : '0;
        pix_b_d = tap.de ? draw_b : '0;
    end

    // Stage 0 feeds the output regs after PIPE further ticks.
    if (PIPE == 0) begin : g_no_dly
        assign tap = s0_q;
    end else begin : g_dly
        tim_t dly_q [PIPE];

        // NOTE: the delay line is reset along with everything else. A reset
        // mid-frame must flush it so no stale de or pulse reaches the pins.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < PIPE; i++) dly_q[i] <= TIM_IDLE;
            end else if (pix_en) begin
                dly_q[0] <= s0_q;
                for (int i = 1; i < PIPE; i++) dly_q[i] <= dly_q[i-1];
            end
        end

        assign tap = dly_q[PIPE-1];
    end

    // NOTE: state registers use non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q      <= '0;
            v_q      <= '0;
            s0_q     <= TIM_IDLE;
            curr_x_q <= '0;
            curr_y_q <= '0;
            out_q    <= TIM_IDLE;
            pix_r_q  <= '0;
            pix_g_q  <= '0;
            pix_b_q  <= '0;
        end else if (pix_en) begin
            h_q      <= h_d;
            v_q      <= v_d;
            s0_q     <= s0_d;
            curr_x_q <= curr_x_d;
            curr_y_q <= curr_y_d;
            out_q    <= out_d;
            pix_r_q  <= pix_r_d;
            pix_g_q  <= pix_g_d;
            pix_b_q  <= pix_b_d;
        end
    end

    assign curr_x      = curr_x_q;
    assign curr_y      = curr_y_q;
    assign coord_valid = s0_q.de;
    assign pix_r       = pix_r_q;
    assign pix_g       = pix_g_q;
    assign pix_b       = pix_b_q;
    assign hsync       = out_q.hs;
    assign vsync       = out_q.vs;
    assign de          = out_q.de;
    assign frame_start = out_q.fs;
    assign line_start  = out_q.ls;

endmodule
